ctrl_unit: RTL and testbench

CTRL_UNIT -- requirements
Module: ctrl_unit

---
 rtl/ctrl_pkg.sv | 91 +++++++++
 rtl/ctrl_decode.sv | 75 +++++++
 rtl/ctrl_unit.sv | 48 ++++
 tb/tb_ctrl_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the MIPS control unit, the hazard unit
// and CP0. Holds the instruction class codes, the opcode/funct/rt field
// constants used by the decoder, and the full eret encoding.
// No ports (package).
package ctrl_pkg;

  typedef enum logic [3:0] {
    IC_NOP   = 4'd0,
    IC_CAL_R = 4'd1,
    IC_CAL_I = 4'd2,
    IC_LOAD  = 4'd3,
    IC_STORE = 4'd4,
    IC_B     = 4'd5,
    IC_J     = 4'd6,
    IC_JAL   = 4'd7,
    IC_JR    = 4'd8,
    IC_JALR  = 4'd9,
    IC_MD    = 4'd10,
    IC_MF    = 4'd11,
    IC_MT    = 4'd12,
    IC_MFC0  = 4'd13,
    IC_MTC0  = 4'd14,
    IC_OTHER = 4'd15
  } ic_e;

  // Opcodes, instr[31:26]
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_REGIMM  = 6'h01;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] OP_BLEZ    = 6'h06;
  localparam logic [5:0] OP_BGTZ    = 6'h07;
  localparam logic [5:0] OP_ADDI    = 6'h08;
  localparam logic [5:0] OP_ADDIU   = 6'h09;
  localparam logic [5:0] OP_SLTI    = 6'h0a;
  localparam logic [5:0] OP_SLTIU   = 6'h0b;
  localparam logic [5:0] OP_ANDI    = 6'h0c;
  localparam logic [5:0] OP_ORI     = 6'h0d;
  localparam logic [5:0] OP_XORI    = 6'h0e;
  localparam logic [5:0] OP_LUI     = 6'h0f;
  localparam logic [5:0] OP_COP0    = 6'h10;
  localparam logic [5:0] OP_LB      = 6'h20;
  localparam logic [5:0] OP_LH      = 6'h21;
  localparam logic [5:0] OP_LW      = 6'h23;
  localparam logic [5:0] OP_LBU     = 6'h24;
  localparam logic [5:0] OP_LHU     = 6'h25;
  localparam logic [5:0] OP_SB      = 6'h28;
  localparam logic [5:0] OP_SH      = 6'h29;
  localparam logic [5:0] OP_SW      = 6'h2b;

  // Funct codes under OP_SPECIAL, instr[5:0]
  localparam logic [5:0] FN_SLL   = 6'h00;
  localparam logic [5:0] FN_SRL   = 6'h02;
  localparam logic [5:0] FN_SRA   = 6'h03;
  localparam logic [5:0] FN_SLLV  = 6'h04;
  localparam logic [5:0] FN_SRLV  = 6'h06;
  localparam logic [5:0] FN_SRAV  = 6'h07;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;
  localparam logic [5:0] FN_MFHI  = 6'h10;
  localparam logic [5:0] FN_MTHI  = 6'h11;
  localparam logic [5:0] FN_MFLO  = 6'h12;
  localparam logic [5:0] FN_MTLO  = 6'h13;
  localparam logic [5:0] FN_MULT  = 6'h18;
  localparam logic [5:0] FN_MULTU = 6'h19;
  localparam logic [5:0] FN_DIV   = 6'h1a;
  localparam logic [5:0] FN_DIVU  = 6'h1b;
  localparam logic [5:0] FN_ADD   = 6'h20;
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUB   = 6'h22;
  localparam logic [5:0] FN_SUBU  = 6'h23;
  localparam logic [5:0] FN_AND   = 6'h24;
  localparam logic [5:0] FN_OR    = 6'h25;
  localparam logic [5:0] FN_XOR   = 6'h26;
  localparam logic [5:0] FN_NOR   = 6'h27;
  localparam logic [5:0] FN_SLT   = 6'h2a;
  localparam logic [5:0] FN_SLTU  = 6'h2b;

  // rt field selectors under OP_REGIMM
  localparam logic [4:0] RT_BLTZ = 5'd0;
  localparam logic [4:0] RT_BGEZ = 5'd1;

  // rs field selectors under OP_COP0
  localparam logic [4:0] RS_MFC0 = 5'd0;
  localparam logic [4:0] RS_MTC0 = 5'd4;

  localparam logic [31:0] ERET_WORD = 32'h4200_0018;

endpackage

// File: rtl/ctrl_decode.sv
// ctrl_decode: purely combinational MIPS instruction classifier.
// Ports:
//   instr [31:0] in  - instruction word
//   ic    [3:0]  out - instruction class (ctrl_pkg::ic_e encoding)
//   ri           out - reserved instruction, high exactly when ic is OTHER
// Config: define CTRL_CP0_EN to decode opcode 0x10 (mfc0, mtc0, eret);
// without it every opcode-0x10 word is reserved.
module ctrl_decode
  import ctrl_pkg::*;
(
  input  logic [31:0] instr,
  output logic [3:0]  ic,
  output logic        ri
);

  logic [5:0] opcode;
  logic [5:0] funct;
  logic [4:0] rt;
  ic_e        cls;

  assign opcode = instr[31:26];
  assign funct  = instr[5:0];
  assign rt     = instr[20:16];

`ifdef CTRL_CP0_EN
  logic [4:0] rs;
  assign rs = instr[25:21];
`endif

  always_comb begin
    cls = IC_OTHER;
    case (opcode)
      OP_SPECIAL: begin
        case (funct)
          FN_ADD, FN_ADDU, FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR,
          FN_SLT, FN_SLTU, FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV,
          FN_SRAV:                           cls = IC_CAL_R;
          FN_JR:                             cls = IC_JR;
          FN_JALR:                           cls = IC_JALR;
          FN_MULT, FN_MULTU, FN_DIV, FN_DIVU: cls = IC_MD;
          FN_MFHI, FN_MFLO:                  cls = IC_MF;
          FN_MTHI, FN_MTLO:                  cls = IC_MT;
          default:                           cls = IC_OTHER;
        endcase
      end
      OP_REGIMM: begin
        if (rt == RT_BLTZ || rt == RT_BGEZ) cls = IC_B;
      end
      OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:      cls = IC_B;
      OP_J:                                  cls = IC_J;
      OP_JAL:                                cls = IC_JAL;
      OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
      OP_ANDI, OP_ORI, OP_XORI, OP_LUI:      cls = IC_CAL_I;
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU:   cls = IC_LOAD;
      OP_SB, OP_SH, OP_SW:                   cls = IC_STORE;
      OP_COP0: begin
`ifdef CTRL_CP0_EN
        // eret redirects the PC, so the pipeline treats it as a jump.
        if (instr == ERET_WORD)    cls = IC_J;
        else if (rs == RS_MFC0)    cls = IC_MFC0;
        else if (rs == RS_MTC0)    cls = IC_MTC0;
`else
        cls = IC_OTHER;
`endif
      end
      default:                               cls = IC_OTHER;
    endcase
    // The all-zero word would otherwise decode as sll; it must be NOP.
    if (instr == 32'h0) cls = IC_NOP;
  end

  assign ic = cls;
  assign ri = (cls == IC_OTHER);

endmodule

// File: rtl/ctrl_unit.sv
// ctrl_unit: MIPS control unit top. Classifies instr combinationally via
// ctrl_decode and also presents the class one Clk later.
// Ports:
//   Clk          in  - clock, rising edge
//   Reset        in  - asynchronous active-low reset (clears ic_q/ri_q only)
//   instr [31:0] in  - instruction word
//   ic    [3:0]  out - combinational class
//   ri           out - combinational reserved-instruction flag
//   ic_q  [3:0]  out - ic registered by one Clk
//   ri_q         out - ri registered by one Clk
// Config: CTRL_CP0_EN enables CP0 instruction decode (see ctrl_decode).
module ctrl_unit
  import ctrl_pkg::*;
(
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] instr,
  output logic [3:0]  ic,
  output logic        ri,
  output logic [3:0]  ic_q,
  output logic        ri_q
);

  logic [3:0] ic_d;
  logic       ri_d;

  ctrl_decode u_decode (
    .instr (instr),
    .ic    (ic),
    .ri    (ri)
  );

  always_comb begin
    ic_d = ic;
    ri_d = ri;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ic_q <= IC_NOP;
      ri_q <= 1'b0;
    end else begin
      ic_q <= ic_d;
      ri_q <= ri_d;
    end
  end

endmodule

// File: tb/tb_ctrl_unit.sv
// tb_ctrl_unit: randomized bench for ctrl_unit with a table-driven class
// model, a per-cycle compare process and literal anchor checks.
module tb_ctrl_unit;

  logic        Clk;
  logic        Reset;
  logic [31:0] instr;
  logic [3:0]  ic;
  logic        ri;
  logic [3:0]  ic_q;
  logic        ri_q;

  int checks = 0;
  int errors = 0;
  bit mon_en = 0;

  // Class lookup tables, indexed by opcode and by funct.
  logic [3:0] op_tbl [64];
  logic [3:0] fn_tbl [64];

  // Expected registered outputs.
  logic [3:0] exp_icq;
  logic       exp_riq;
  logic [3:0] exp_q [$];

  ctrl_unit dut (
    .Clk   (Clk),
    .Reset (Reset),
    .instr (instr),
    .ic    (ic),
    .ri    (ri),
    .ic_q  (ic_q),
    .ri_q  (ri_q)
  );

  // ---------------- clock / reset ----------------
  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ---------------- model ----------------
  task automatic fill_tables();
    int cal_r [16] = '{'h20,'h21,'h22,'h23,'h24,'h25,'h26,'h27,'h2a,'h2b,0,2,3,4,6,7};
    int cal_i [8]  = '{8,9,'ha,'hb,'hc,'hd,'he,'hf};
    int ld    [5]  = '{'h20,'h21,'h23,'h24,'h25};
    int st    [3]  = '{'h28,'h29,'h2b};
    int br    [4]  = '{4,5,6,7};
    for (int i = 0; i < 64; i++) begin
      op_tbl[i] = 4'd15;
      fn_tbl[i] = 4'd15;
    end
    foreach (cal_r[i]) fn_tbl[cal_r[i]] = 4'd1;
    fn_tbl[8'h08] = 4'd8;
    fn_tbl[8'h09] = 4'd9;
    for (int i = 'h18; i <= 'h1b; i++) fn_tbl[i] = 4'd10;
    fn_tbl[8'h10] = 4'd11;
    fn_tbl[8'h12] = 4'd11;
    fn_tbl[8'h11] = 4'd12;
    fn_tbl[8'h13] = 4'd12;
    foreach (cal_i[i]) op_tbl[cal_i[i]] = 4'd2;
    foreach (ld[i])    op_tbl[ld[i]]    = 4'd3;
    foreach (st[i])    op_tbl[st[i]]    = 4'd4;
    foreach (br[i])    op_tbl[br[i]]    = 4'd5;
    op_tbl[2] = 4'd6;
    op_tbl[3] = 4'd7;
  endtask

  function automatic logic [3:0] model_cls(input logic [31:0] w);
    int op = int'(w[31:26]);
    int rs = int'(w[25:21]);
    int rt = int'(w[20:16]);
    if (w == 32'h0) return 4'd0;
    if (op == 0) return fn_tbl[w[5:0]];
    if (op == 1) return (rt <= 1) ? 4'd5 : 4'd15;
    if (op == 16) begin
`ifdef CTRL_CP0_EN
      if (w == 32'h4200_0018) return 4'd6;
      if (rs == 0) return 4'd13;
      if (rs == 4) return 4'd14;
`endif
      return 4'd15;
    end
    return op_tbl[op];
  endfunction

  // Registered model: what was classified at the last capturing edge.
  always @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      exp_icq = 4'd0;
      exp_riq = 1'b0;
    end else begin
      exp_icq = model_cls(instr);
      exp_riq = (exp_icq == 4'd15);
      exp_q.push_back(exp_icq);
    end
  end

  // ---------------- scoreboard ----------------
  function automatic void chk(input string name, input logic [31:0] act,
                              input logic [31:0] exp, input logic [31:0] w);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s instr=%08h got=%0h expected=%0h at %0t", name, w, act, exp, $time);
    end
  endfunction

  always @(negedge Clk) begin
    if (mon_en) begin
      logic [3:0] m;
      m = model_cls(instr);
      chk("ic", 32'(ic), 32'(m), instr);
      chk("ri", 32'(ri), 32'(m == 4'd15), instr);
      chk("ic_q", 32'(ic_q), 32'(exp_icq), instr);
      chk("ri_q", 32'(ri_q), 32'(exp_riq), instr);
    end
  end

  // ---------------- driver tasks ----------------
  // Apply a word mid-cycle and check the combinational outputs and the
  // model against a hand-computed class.
  task automatic lit(input logic [31:0] w, input logic [3:0] exp_cls);
    @(posedge Clk);
    #2 instr = w;
    #1;
    chk("lit_ic", 32'(ic), 32'(exp_cls), w);
    chk("lit_ri", 32'(ri), 32'(exp_cls == 4'd15), w);
    chk("lit_model", 32'(model_cls(w)), 32'(exp_cls), w);
  endtask

  function automatic logic [31:0] rand_word();
    int sel = $urandom_range(0, 9);
    logic [31:0] w = $urandom;
    logic [5:0]  ops [12] = '{0,0,0,1,2,3,4,8,16,16,6'h23,6'h2b};
    case (sel)
      0: w = 32'h0;
      1: w = 32'h4200_0018;
      2, 3, 4, 5: begin
        w[31:26] = ops[$urandom_range(0, 11)];
        w[5:0]   = 6'($urandom_range(0, 6'h2b));
      end
      6, 7: begin
        w[31:26] = ops[$urandom_range(0, 11)];
        w[25:21] = ($urandom_range(0, 1) != 0) ? 5'd0 : 5'd4;
        w[20:16] = 5'($urandom_range(0, 3));
      end
      default: ;
    endcase
    return w;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    fill_tables();
    instr = 32'h0;
    Reset = 1'b1;
    #1 Reset = 1'b0;
    #2;
    chk("rst_ic_q", 32'(ic_q), 32'd0, instr);
    chk("rst_ri_q", 32'(ri_q), 32'd0, instr);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    mon_en = 1;

    // addu: comb class now, registered class after one edge
    lit(32'h0043_0821, 4'd1);
    @(posedge Clk);
    #1 chk("addu_ic_q", 32'(ic_q), 32'd1, instr);

    lit(32'h8C22_0004, 4'd3);
    lit(32'hAC22_0004, 4'd4);
    lit(32'h1022_0003, 4'd5);
    lit(32'h0411_0002, 4'd15);
    lit(32'h0C00_0010, 4'd7);
    lit(32'h03E0_0008, 4'd8);
    lit(32'h0060_F809, 4'd9);
    lit(32'h0800_0010, 4'd6);
`ifdef CTRL_CP0_EN
    lit(32'h4200_0018, 4'd6);
    lit(32'h4001_6000, 4'd13);
    lit(32'h4081_6000, 4'd14);
`else
    lit(32'h4200_0018, 4'd15);
    lit(32'h4001_6000, 4'd15);
    lit(32'h4081_6000, 4'd15);
`endif
    lit(32'h0000_0000, 4'd0);
    lit(32'h0000_0010, 4'd11);
    lit(32'h0022_0018, 4'd10);
    lit(32'h0020_0011, 4'd12);
    lit(32'h0000_0040, 4'd1);
    lit(32'h0400_0000, 4'd5);
    lit(32'hFC00_0000, 4'd15);

    // Mid-run reset: ic_q currently holds OTHER/ri=1 and must clear at once.
    @(posedge Clk);
    #1 chk("pre_rst_ri_q", 32'(ri_q), 32'd1, instr);
    #1 Reset = 1'b0;
    #1;
    chk("mid_rst_ic_q", 32'(ic_q), 32'd0, instr);
    chk("mid_rst_ri_q", 32'(ri_q), 32'd0, instr);
    chk("mid_rst_ic", 32'(ic), 32'd15, instr);
    chk("mid_rst_ri", 32'(ri), 32'd1, instr);
    repeat (2) @(posedge Clk);
    #1 chk("held_rst_ic_q", 32'(ic_q), 32'd0, instr);
    #1 Reset = 1'b1;
    @(posedge Clk);
    #1 chk("resume_ic_q", 32'(ic_q), 32'd15, instr);

    // Randomized traffic, checked every cycle by the compare process.
    for (int n = 0; n < 2000; n++) begin
      @(posedge Clk);
      #2 instr = rand_word();
      if (n == 1000) begin
        #1 Reset = 1'b0;
        #3 Reset = 1'b1;
      end
    end
    @(posedge Clk);
    @(negedge Clk);
    mon_en = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
